// File: rtl/mem_responder.sv
// LC-3 style memory responder: fixed-latency RAM access plus memory-mapped
// keyboard (KBSR/KBDR) and display (DSR/DDR) device registers.
module mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        mio_en,
    input  logic        rw,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mdr_out,
    output logic        ready,
    input  logic        kb_strobe,
    input  logic [7:0]  kb_char,
    input  logic        disp_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_char
);

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state, next_state;
    logic [3:0]  cnt, cnt_next;
    logic        sample;
    logic        complete;

    logic [15:0] lat_addr;
    logic [15:0] lat_data;
    logic        lat_rw;

    logic [15:0] mem [0:(2**ADDR_BITS)-1];

    logic        kb_rdy;
    logic        kb_ovr;
    logic [7:0]  kbdr;

    logic        is_io;
    logic        do_read;
    logic        do_write;
    logic        rd_kbdr;
    logic        wr_ddr;
    logic [15:0] rd_data;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (aclr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        sample     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (mio_en) begin
                    sample     = 1'b1;
                    next_state = BUSY;
                    cnt_next   = 4'(WAIT_CYCLES);
                end
            end
            BUSY: begin
                if (cnt == 4'd1) begin
                    complete   = 1'b1;
                    next_state = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ---------------- access decode ----------------
    always_comb begin
        is_io    = (lat_addr == KBSR_ADDR) || (lat_addr == KBDR_ADDR) ||
                   (lat_addr == DSR_ADDR)  || (lat_addr == DDR_ADDR);
        do_read  = complete && !lat_rw;
        do_write = complete && lat_rw;
        rd_kbdr  = do_read && (lat_addr == KBDR_ADDR);
        wr_ddr   = do_write && (lat_addr == DDR_ADDR);
    end

    always_comb begin
        rd_data = '0;
        case (lat_addr)
            KBSR_ADDR: rd_data = {kb_rdy, kb_ovr, 14'b0};
            KBDR_ADDR: rd_data = {8'b0, kbdr};
            DSR_ADDR:  rd_data = {disp_ready, 15'b0};
            DDR_ADDR:  rd_data = {8'b0, disp_char};
            default:   rd_data = mem[lat_addr[ADDR_BITS-1:0]];
        endcase
    end

    // ---------------- request latch ----------------
    always_ff @(posedge clk) begin
        if (aclr) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_rw   <= 1'b0;
        end else if (sample) begin
            lat_addr <= mar;
            lat_data <= mdr_in;
            lat_rw   <= rw;
        end
    end

    // RAM keeps its contents across reset; aclr only blocks the write.
    always_ff @(posedge clk) begin
        if (!aclr && do_write && !is_io) begin
            mem[lat_addr[ADDR_BITS-1:0]] <= lat_data;
        end
    end

    // ---------------- response / display ----------------
    always_ff @(posedge clk) begin
        if (aclr) begin
            ready      <= 1'b0;
            mdr_out    <= '0;
            disp_valid <= 1'b0;
            disp_char  <= '0;
        end else begin
            ready      <= complete;
            disp_valid <= wr_ddr;
            if (do_read) begin
                mdr_out <= rd_data;
            end
            if (wr_ddr) begin
                disp_char <= lat_data[7:0];
            end
        end
    end

    // A strobe landing on a KBDR read completion is treated as arriving
    // just after the read: the read clears status, then the new char lands.
    always_ff @(posedge clk) begin
        if (aclr) begin
            kbdr   <= '0;
            kb_rdy <= 1'b0;
            kb_ovr <= 1'b0;
        end else if (kb_strobe) begin
            if (kb_rdy && !rd_kbdr) begin
                kb_ovr <= 1'b1;
            end else begin
                kbdr   <= kb_char;
                kb_rdy <= 1'b1;
                if (rd_kbdr) begin
                    kb_ovr <= 1'b0;
                end
            end
        end else if (rd_kbdr) begin
            kb_rdy <= 1'b0;
            kb_ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: read results queued at issue, compared
// when ready pulses; latency, device registers and reset abort also checked.
module tb_mem_responder;

    localparam int ADDR_BITS   = 8;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        aclr;
    logic        mio_en;
    logic        rw;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mdr_out;
    logic        ready;
    logic        kb_strobe;
    logic [7:0]  kb_char;
    logic        disp_ready;
    logic        disp_valid;
    logic [7:0]  disp_char;

    int checks = 0;
    int errors = 0;
    int ready_count = 0;
    int dv_count = 0;
    logic rd_flag = 1'b0;
    logic [15:0] sb[$];

    mem_responder #(
        .ADDR_BITS  (ADDR_BITS),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .aclr      (aclr),
        .mio_en    (mio_en),
        .rw        (rw),
        .mar       (mar),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ready     (ready),
        .kb_strobe (kb_strobe),
        .kb_char   (kb_char),
        .disp_ready(disp_ready),
        .disp_valid(disp_valid),
        .disp_char (disp_char)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready) ready_count++;
        if (disp_valid) dv_count++;
        if (ready && rd_flag) begin
            if (sb.size() == 0) check("sb_underflow", 16'(sb.size()), 16'd1);
            else check("rdata", mdr_out, sb.pop_front());
        end
    end

    // Issue one access; optionally raise kb_strobe so it is high at edge sedge.
    task automatic access(input string tag, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp,
                          input logic [7:0] sc, input int sedge);
        int lat;
        bit got;
        mio_en = 1'b1;
        rw     = w;
        mar    = a;
        mdr_in = d;
        rd_flag = !w;
        if (!w) sb.push_back(exp);
        @(posedge clk);
        #1 mio_en = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (i == sedge) begin
                kb_strobe = 1'b1;
                kb_char   = sc;
            end
            @(posedge clk);
            #1 kb_strobe = 1'b0;
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                lat = i;
            end
        end
        check({tag, "_ready_edge"}, 16'(lat), 16'(WAIT_CYCLES));
        @(negedge clk);
        check({tag, "_ready_pulse"}, {15'b0, ready}, 16'h0000);
    endtask

    task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d);
        access(tag, 1'b1, a, d, 16'h0000, 8'h00, 0);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        access(tag, 1'b0, a, 16'h0000, exp, 8'h00, 0);
    endtask

    task automatic kb_press(input logic [7:0] c);
        @(negedge clk);
        kb_strobe = 1'b1;
        kb_char   = c;
        @(posedge clk);
        #1 kb_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int rc;
        int dc;
        aclr = 1'b1; mio_en = 1'b0; rw = 1'b0; mar = '0; mdr_in = '0;
        kb_strobe = 1'b0; kb_char = '0; disp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mdr_out", mdr_out, 16'h0000);
        check("rst_ready", {15'b0, ready}, 16'h0000);
        check("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        check("rst_disp_char", {8'b0, disp_char}, 16'h0000);
        aclr = 1'b0;

        // Write/read and aliasing
        wr("w3000", 16'h3000, 16'h1234);
        rd("r3000", 16'h3000, 16'h1234);
        wr("w0005", 16'h0005, 16'hBEEF);
        rd("r0105", 16'h0105, 16'hBEEF);
        rd("r3000b", 16'h3000, 16'h1234);

        // Keyboard basic
        rd("kbsr0", 16'hFE00, 16'h0000);
        kb_press(8'h41);
        rd("kbsr1", 16'hFE00, 16'h8000);
        rd("kbdr1", 16'hFE02, 16'h0041);
        rd("kbsr2", 16'hFE00, 16'h0000);

        // Overrun, then strobe coincident with KBDR read completion
        kb_press(8'h41);
        kb_press(8'h42);
        rd("kbsr_ovr", 16'hFE00, 16'hC000);
        access("kbdr_coll", 1'b0, 16'hFE02, 16'h0000, 16'h0041, 8'h43, WAIT_CYCLES);
        rd("kbsr_coll", 16'hFE00, 16'h8000);
        rd("kbdr_coll2", 16'hFE02, 16'h0043);

        // Writes to device status/data regs are ignored
        wr("w_kbsr", 16'hFE00, 16'hFFFF);
        wr("w_dsr", 16'hFE04, 16'hFFFF);
        rd("kbsr_ign", 16'hFE00, 16'h0000);

        // Display
        disp_ready = 1'b0;
        dc = dv_count;
        wr("w_ddr", 16'hFE06, 16'h0158);
        check("dv_pulses", 16'(dv_count - dc), 16'd1);
        check("disp_char", {8'b0, disp_char}, 16'h0058);
        rd("dsr0", 16'hFE04, 16'h0000);
        rd("ddr", 16'hFE06, 16'h0058);
        disp_ready = 1'b1;
        rd("dsr1", 16'hFE04, 16'h8000);

        // Reset during BUSY aborts the write
        wr("w0010", 16'h0010, 16'h1111);
        rc = ready_count;
        dc = dv_count;
        @(negedge clk);
        mio_en = 1'b1; rw = 1'b1; mar = 16'h0010; mdr_in = 16'h5555;
        @(posedge clk);
        #1 mio_en = 1'b0;
        @(posedge clk);
        #1 aclr = 1'b1;
        @(posedge clk);
        #1 aclr = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_ready", 16'(ready_count - rc), 16'd0);
        check("abort_mdr_out", mdr_out, 16'h0000);
        rd("r0010", 16'h0010, 16'h1111);

        // DDR write aborted by reset: no display pulse
        dc = dv_count;
        @(negedge clk);
        mio_en = 1'b1; rw = 1'b1; mar = 16'hFE06; mdr_in = 16'h0077;
        @(posedge clk);
        #1 mio_en = 1'b0;
        @(posedge clk);
        #1 aclr = 1'b1;
        @(posedge clk);
        #1 aclr = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_dv", 16'(dv_count - dc), 16'd0);
        check("abort_disp_char", {8'b0, disp_char}, 16'h0000);

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
